// File: rtl/csel_pkg.sv
// Shared constants and the stage-1 per-block candidate record for csel_pipe_adder.
package csel_pkg;

  localparam int CSEL_WIDTH   = 16;
  localparam int CSEL_BLK     = 4;
  // Candidate sums are stored at this width; blocks narrower than it zero-extend.
  localparam int CSEL_BLK_MAX = 16;

  typedef struct packed {
    logic [CSEL_BLK_MAX-1:0] sum0;
    logic [CSEL_BLK_MAX-1:0] sum1;
    logic                    c0;
    logic                    c1;
  } csel_cand_t;

endpackage

// File: rtl/csel_block.sv
// BLK-bit ripple adder producing both candidate results: block carry-in 0 (sum0/c0)
// and block carry-in 1 (sum1/c1).
module csel_block #(
  parameter int BLK = 4
) (
  input  logic [BLK-1:0] a,
  input  logic [BLK-1:0] b,
  output logic [BLK-1:0] sum0,
  output logic           c0,
  output logic [BLK-1:0] sum1,
  output logic           c1
);

  logic r0;
  logic r1;

  always_comb begin
    r0   = 1'b0;
    r1   = 1'b1;
    sum0 = '0;
    sum1 = '0;
    for (int i = 0; i < BLK; i++) begin
      sum0[i] = a[i] ^ b[i] ^ r0;
      r0      = (a[i] & b[i]) | (r0 & (a[i] ^ b[i]));
      sum1[i] = a[i] ^ b[i] ^ r1;
      r1      = (a[i] & b[i]) | (r1 & (a[i] ^ b[i]));
    end
    c0 = r0;
    c1 = r1;
  end

endmodule

// File: rtl/csel_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready flow control.
// Define CSEL_OVF_EN to add the pipelined signed-overflow output ovf.
module csel_pipe_adder
  import csel_pkg::*;
#(
  parameter int WIDTH = CSEL_WIDTH,
  parameter int BLK   = CSEL_BLK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CSEL_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NB = WIDTH / BLK;

  if (BLK < 1 || BLK > CSEL_BLK_MAX || (WIDTH % BLK) != 0) begin : g_bad_cfg
    $error("csel_pipe_adder: WIDTH must be a multiple of BLK, 1 <= BLK <= CSEL_BLK_MAX");
  end

  // Valid/ready: a beat crosses a boundary on a rising edge where the sender's valid and
  // the receiver's ready are both high; valid never depends on ready, and a stalled
  // stage holds its contents unchanged.
  logic             adv1;
  logic             adv2;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [BLK-1:0]   bs0 [NB];
  logic [BLK-1:0]   bs1 [NB];
  logic             bc0 [NB];
  logic             bc1 [NB];

  logic             v1_q, v1_d;
  logic             v2_q, v2_d;
  csel_cand_t       cand_q [NB];
  csel_cand_t       cand_d [NB];
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] sel_s;
  logic             carry;
`ifdef CSEL_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  always_comb begin
    b_eff = sub ? ~b : b;
    c_eff = sub ? ~cin : cin;
  end

  for (genvar k = 0; k < NB; k++) begin : g_blk
    csel_block #(.BLK(BLK)) u_blk (
      .a    (a[k*BLK +: BLK]),
      .b    (b_eff[k*BLK +: BLK]),
      .sum0 (bs0[k]),
      .c0   (bc0[k]),
      .sum1 (bs1[k]),
      .c1   (bc1[k])
    );
  end

  always_comb begin
    adv2     = !v2_q || out_ready;
    adv1     = !v1_q || adv2;
    in_ready = adv1;
    v1_d     = adv1 ? in_valid : v1_q;
    v2_d     = adv2 ? v1_q : v2_q;

    for (int k = 0; k < NB; k++) begin
      cand_d[k] = cand_q[k];
      if (adv1 && in_valid) begin
        cand_d[k].sum0 = CSEL_BLK_MAX'(bs0[k]);
        cand_d[k].sum1 = CSEL_BLK_MAX'(bs1[k]);
        cand_d[k].c0   = bc0[k];
        cand_d[k].c1   = bc1[k];
      end
    end
    // Block 0 resolves the real carry-in now, so both its slots carry the final result
    // and stage 2 can treat it like any other block with carry-in 0.
    if (adv1 && in_valid) begin
      cand_d[0].sum0 = c_eff ? CSEL_BLK_MAX'(bs1[0]) : CSEL_BLK_MAX'(bs0[0]);
      cand_d[0].c0   = c_eff ? bc1[0] : bc0[0];
      cand_d[0].sum1 = cand_d[0].sum0;
      cand_d[0].c1   = cand_d[0].c0;
    end

    carry = 1'b0;
    sel_s = '0;
    for (int k = 0; k < NB; k++) begin
      sel_s[k*BLK +: BLK] = carry ? cand_q[k].sum1[BLK-1:0] : cand_q[k].sum0[BLK-1:0];
      carry               = carry ? cand_q[k].c1 : cand_q[k].c0;
    end

    s_d    = s_q;
    cout_d = cout_q;
    if (adv2 && v1_q) begin
      s_d    = sel_s;
      cout_d = carry;
    end

`ifdef CSEL_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
    if (adv1 && in_valid) begin
      a_msb_d = a[WIDTH-1];
      b_msb_d = b_eff[WIDTH-1];
    end
    if (adv2 && v1_q) begin
      ovf_d = (a_msb_q == b_msb_q) && (sel_s[WIDTH-1] != a_msb_q);
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      s_q    <= '0;
      cout_q <= 1'b0;
      for (int k = 0; k < NB; k++) begin
        cand_q[k] <= '0;
      end
`ifdef CSEL_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      s_q    <= s_d;
      cout_q <= cout_d;
      for (int k = 0; k < NB; k++) begin
        cand_q[k] <= cand_d[k];
      end
`ifdef CSEL_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign out_valid = v2_q;
  assign s         = s_q;
  assign cout      = cout_q;
`ifdef CSEL_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_csel_pipe_adder.sv
// Scoreboard bench for csel_pipe_adder (WIDTH=16, BLK=4): directed vectors, stall,
// mid-operation reset and a long random run against an arithmetic reference model.
module tb_csel_pipe_adder;

  localparam int W  = 16;
  localparam int RW = W + 2;
`ifdef CSEL_OVF_EN
  localparam logic [RW-1:0] CMP_MASK = {RW{1'b1}};
`else
  localparam logic [RW-1:0] CMP_MASK = {1'b0, {(W+1){1'b1}}};
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] s;
  logic         cout;
`ifdef CSEL_OVF_EN
  logic         ovf;
`endif

  csel_pipe_adder #(.WIDTH(W), .BLK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef CSEL_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [RW-1:0] exp_q[$];
  int ready_mode = 1;  // 0 random, 1 always ready, 2 never ready

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endfunction

  // Reference: plain integer arithmetic; result packed as {ovf, cout, s}.
  function automatic logic [RW-1:0] model(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                          input logic c, input logic sb);
    longint r;
    longint sr;
    logic   co;
    logic   ov;
    if (sb) begin
      r  = longint'(aa) - longint'(bb) - longint'(c);
      co = (r >= 0);
      sr = longint'($signed(aa)) - longint'($signed(bb)) - longint'(c);
    end else begin
      r  = longint'(aa) + longint'(bb) + longint'(c);
      co = (r >= (longint'(1) << W));
      sr = longint'($signed(aa)) + longint'($signed(bb)) + longint'(c);
    end
    ov = (sr > ((longint'(1) << (W-1)) - 1)) || (sr < -(longint'(1) << (W-1)));
    return {ov, co, W'(r)};
  endfunction

  function automatic logic [RW-1:0] dut_word();
`ifdef CSEL_OVF_EN
    return {ovf, cout, s};
`else
    return {1'b0, cout, s};
`endif
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(7))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return W'($urandom);
    endcase
  endfunction

  // out_ready driver
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       out_ready = ($urandom_range(99) < 70);
        1:       out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Driver: present a beat, wait for acceptance, push its expected result.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic c,
                      input logic sb, input logic use_e, input logic [RW-1:0] e);
    int guard = 0;
    @(negedge clk);
    a = aa; b = bb; cin = c; sub = sb; in_valid = 1'b1;
    #1;
    while (!in_ready) begin
      guard++;
      if (guard > 200) begin
        n_checks++;
        $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    exp_q.push_back(use_e ? e : model(aa, bb, c, sb));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_rand();
    send(rand_op(), rand_op(), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'b0, '0);
  endtask

  task automatic wait_drain();
    int guard = 0;
    ready_mode = 1;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    #2;
    check("drain_remaining", 32'(exp_q.size()), 32'd0);
  endtask

  // Scoreboard monitor
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        check("in_ready", 32'(in_ready), 32'((exp_q.size() < 2) || out_ready));
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_out: out_valid=1 with s=0x%0h, expected no beat", s);
          end else begin
            check("result", 32'(dut_word() & CMP_MASK), 32'(exp_q[0] & CMP_MASK));
            if (out_ready) void'(exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef CSEL_OVF_EN
    check("rst_ovf", 32'(ovf), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // latency: carry crossing a block boundary
    send(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h0100});
    @(negedge clk);
    #1;
    check("lat_edge1_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    #1;
    check("lat_edge2_out_valid", 32'(out_valid), 32'd1);
    check("lat_s", 32'(s), 32'h0100);

    // directed vectors, back to back, mixing add and subtract
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b0, 1'b1, 16'h0000});
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 16'h8000});
    send(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0002});
    send(16'h0007, 16'h0005, 1'b1, 1'b1, 1'b1, {1'b0, 1'b1, 16'h0001});
    send(16'h000F, 16'h0000, 1'b1, 1'b0, 1'b1, {1'b0, 1'b0, 16'h0010});
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 16'h7FFF});
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 1'b1, {1'b0, 1'b0, 16'h5555});
    wait_drain();

    // 8 beats with a 3-cycle output stall mid-stream
    fork
      begin
        for (int i = 0; i < 8; i++) send_rand();
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 2;
        repeat (3) @(posedge clk);
        #1;
        ready_mode = 1;
      end
    join
    wait_drain();

    // reset with both stages full
    ready_mode = 2;
    send_rand();
    send_rand();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_s", 32'(s), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    ready_mode = 1;
    for (int i = 0; i < 4; i++) send_rand();
    wait_drain();

    // long random run with random idles and backpressure
    ready_mode = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        a = W'($urandom);
        b = W'($urandom);
      end
      send_rand();
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
